vending_machine_multi: RTL
==========================

Name: vending_machine_multi

Overview:
Parametrised successor to the single-product-set drink FSM. Supports N_DRINKS products with a price table, per-product stock counters and restock, a credit ceiling with coin rejection, and optional multi-vend (keep the remaining credit for another selection). Sits between the coin/keypad front-end and the dispenser/change-hopper drivers. Every output is registered.

Parameters:
MONEY_W, 8, width of coin, credit, price and change values
N_DRINKS, 4, number of products; selection codes 1..N_DRINKS
SEL_W, 3, selection code width; must satisfy 2^SEL_W > N_DRINKS
PRICES, {8'd25,8'd20,8'd15,8'd10}, packed N_DRINKS*MONEY_W price table; product k uses slice k-1
STOCK_W, 4, stock counter width
STOCK_INIT, 5, stock of every product after reset
MAX_CREDIT, 99, credit ceiling
MULTI_VEND, 0, 1 = after a vend, stay in CREDIT while the remaining credit is at least the minimum price

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
coin_valid  in  1  coin present this cycle
coin_amt  in  MONEY_W  coin value
sel_valid  in  1  selection strobe
sel  in  SEL_W  product code
cancel  in  1  refund request (synchronous, level sampled)
restock_valid  in  1  restock strobe
restock_idx  in  SEL_W  product to restock
restock_cnt  in  STOCK_W  units added
credit  out  MONEY_W  current credit
drink_valid  out  1  one-cycle dispense pulse
drink_idx  out  SEL_W  dispensed product; valid with drink_valid
change_valid  out  1  one-cycle change pulse
change_amt  out  MONEY_W  change value; valid with change_valid
coin_reject  out  1  one-cycle pulse: coin returned unaccepted
sel_reject  out  1  one-cycle pulse: selection refused
sel_err  out  2  01 bad code, 10 sold out, 11 insufficient credit; valid with sel_reject
sold_out  out  N_DRINKS  bit k-1 high when stock of product k is 0
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset values: state IDLE; credit, all pulses, drink_idx, change_amt and sel_err = 0. All stock = STOCK_INIT. Reset mid-transaction discards credit with no change pulse.
- States: IDLE (credit = 0), CREDIT, VEND, CHANGE. All pulses last exactly one cycle and are 0 otherwise.
- Coin, accepted in IDLE or CREDIT only:
  - If credit + coin_amt <= MAX_CREDIT: credit updates on the next edge and the state goes to CREDIT.
  - Otherwise: coin_reject and credit unchanged.
  - The sum is computed at MONEY_W+1 bits.
  - coin_amt = 0 with coin_valid is ignored; no pulse.
- Selection, in CREDIT only:
  - Code 0 or greater than N_DRINKS: error 01.
  - Stock = 0: error 10.
  - credit < price: error 11.
  - Errors are checked in that order. On error, sel_reject pulses and the state is unchanged.
  - On a valid selection: next cycle the state is VEND, drink_valid = 1, drink_idx = sel, credit -= price, stock decrements.
  - In IDLE, sel_valid gives sel_reject with error 11.
- VEND lasts 1 cycle:
  - If MULTI_VEND = 1 and credit >= minimum price: go to CREDIT.
  - Else if credit > 0: go to CHANGE.
  - Else: go to IDLE.
- CHANGE lasts 1 cycle: change_valid = 1, change_amt = credit, credit = 0, then IDLE.
- Cancel:
  - In CREDIT: go to CHANGE.
  - In IDLE: no-op; no change pulse.
  - Ignored in VEND and CHANGE.
- Same-cycle priority: cancel > selection > coin.
  - A coin arriving with an accepted cancel or selection gets coin_reject.
  - A selection arriving with cancel is silently dropped.
  - coin_valid or sel_valid during VEND or CHANGE: coin_reject, or silently dropped selection.
- Restock, accepted in any state:
  - stock += restock_cnt, saturating at 2^STOCK_W-1.
  - Invalid restock_idx is ignored.
  - Restock and vend on the same product in the same cycle: both apply (net = stock - 1 + cnt, saturated).
- sold_out is registered from the stock values and follows them by 0 cycles, i.e. it reflects the current stock registers.

Decomposition:
- Package vending_pkg holds:
  - state enum (IDLE/CREDIT/VEND/CHANGE);
  - sel_err codes (ERR_NONE/ERR_CODE/ERR_SOLD/ERR_FUNDS);
  - function price_of(idx) extracting a slice of PRICES;
  - function min_price.
- One sub-module, vm_stock_bank: N_DRINKS saturating counters with vend-decrement and restock ports, producing the stock and sold_out vectors.

Test Plan:
1. Insert 10 then 15 → credit 25. Select 4 (25) → drink_valid with idx 4, then IDLE with no change pulse; stock[4] = 4.
2. Insert 50, select 1 (10), MULTI_VEND = 0 → drink idx 1, then change_valid with change_amt 40, credit 0.
3. MULTI_VEND = 1: insert 30, select 1 → credit 20 in CREDIT. Select 3 (20) → credit 0, IDLE, no change.
4. Credit 95, insert 10 → coin_reject, credit stays 95. Cancel → change_amt 95.
5. Vend product 2 five times → sold_out[1] = 1; the sixth selection gives sel_err 10. Restock idx 2 by 3 → sold_out[1] = 0, stock 3. Select 0 → sel_err 01.
6. Credit 20 with cancel, sel = 1 and a coin of 5 in one cycle → change_amt 20, coin_reject, no drink. Assert rst during VEND → all outputs 0, stock = 5.

Source files
------------

// File: rtl/vending_machine_multi_pkg.sv
// Shared types and price-table helpers for the multi-product vending controller.
package vending_pkg;

  localparam int TBL_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_CODE  = 2'b01,
    ERR_SOLD  = 2'b10,
    ERR_FUNDS = 2'b11
  } sel_err_t;

  // Product idx (1-based) lives in slice idx-1 of the packed table.
  function automatic logic [31:0] price_of(input logic [TBL_MAX_W-1:0] tbl,
                                           input int unsigned idx,
                                           input int unsigned money_w);
    logic [TBL_MAX_W-1:0] sh;
    logic [31:0]          mask;
    sh   = tbl >> ((idx - 1) * money_w);
    mask = (money_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << money_w) - 32'd1);
    return sh[31:0] & mask;
  endfunction

  function automatic logic [31:0] min_price(input logic [TBL_MAX_W-1:0] tbl,
                                            input int unsigned n,
                                            input int unsigned money_w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    for (int unsigned k = 1; k <= n; k++) begin
      if (price_of(tbl, k, money_w) < m) m = price_of(tbl, k, money_w);
    end
    return m;
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / dispenser bundle of the vending controller; master = front-end, slave = controller.
interface vending_machine_multi_if
  import vending_pkg::*;
#(
  parameter int MONEY_W  = 8,
  parameter int SEL_W    = 3,
  parameter int STOCK_W  = 4,
  parameter int N_DRINKS = 4
);
  logic               coin_valid;
  logic [MONEY_W-1:0] coin_amt;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel;
  logic               cancel;
  logic               restock_valid;
  logic [SEL_W-1:0]   restock_idx;
  logic [STOCK_W-1:0] restock_cnt;

  logic [MONEY_W-1:0]  credit;
  logic                drink_valid;
  logic [SEL_W-1:0]    drink_idx;
  logic                change_valid;
  logic [MONEY_W-1:0]  change_amt;
  logic                coin_reject;
  logic                sel_reject;
  sel_err_t            sel_err;
  logic [N_DRINKS-1:0] sold_out;
  logic                busy;

  modport master (
    output coin_valid, coin_amt, sel_valid, sel, cancel,
           restock_valid, restock_idx, restock_cnt,
    input  credit, drink_valid, drink_idx, change_valid, change_amt,
           coin_reject, sel_reject, sel_err, sold_out, busy
  );

  modport slave (
    input  coin_valid, coin_amt, sel_valid, sel, cancel,
           restock_valid, restock_idx, restock_cnt,
    output credit, drink_valid, drink_idx, change_valid, change_amt,
           coin_reject, sel_reject, sel_err, sold_out, busy
  );
endinterface

// File: rtl/vending_machine_multi_stock.sv
// Per-product saturating stock counters; vend and restock apply in the same edge.
module vm_stock_bank
  import vending_pkg::*;
#(
  parameter int N_DRINKS   = 4,
  parameter int SEL_W      = 3,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vend_valid,
  input  logic [SEL_W-1:0]    vend_idx,
  input  logic                restock_valid,
  input  logic [SEL_W-1:0]    restock_idx,
  input  logic [STOCK_W-1:0]  restock_cnt,
  output logic [N_DRINKS-1:0] sold_out
);
  localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};
  localparam logic [STOCK_W:0] ONE       = {{STOCK_W{1'b0}}, 1'b1};

  for (genvar k = 0; k < N_DRINKS; k++) begin : g_slot
    logic [STOCK_W-1:0] cnt_q;
    logic [STOCK_W:0]   nxt;

    // One spare bit so the vend-then-restock sum can be clamped.
    always_comb begin
      nxt = {1'b0, cnt_q};
      if (vend_valid && (int'(vend_idx) == k + 1) && (cnt_q != '0)) nxt = nxt - ONE;
      if (restock_valid && (int'(restock_idx) == k + 1)) nxt = nxt + {1'b0, restock_cnt};
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= STOCK_W'(STOCK_INIT);
      else     cnt_q <= (nxt > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : nxt[STOCK_W-1:0];
    end

    assign sold_out[k] = (cnt_q == '0);
  end
endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, priced selection, change and restock.
// Accepted inputs take effect on the next edge; all pulses are registered and one cycle wide.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int                          MONEY_W    = 8,
  parameter int                          N_DRINKS   = 4,
  parameter int                          SEL_W      = 3,
  parameter logic [N_DRINKS*MONEY_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int                          STOCK_W    = 4,
  parameter int                          STOCK_INIT = 5,
  parameter int                          MAX_CREDIT = 99,
  parameter int                          MULTI_VEND = 0
) (
  input logic                   clk,
  input logic                   rst,
  vending_machine_multi_if.slave bus
);
  localparam logic [TBL_MAX_W-1:0] TBL       = TBL_MAX_W'(PRICES);
  localparam logic [MONEY_W-1:0]   MIN_PRICE = MONEY_W'(min_price(TBL, N_DRINKS, MONEY_W));
  localparam logic [MONEY_W:0]     MAX_C     = (MONEY_W + 1)'(MAX_CREDIT);

  state_t              state;
  logic [MONEY_W-1:0]  credit_q;
  logic                drink_q;
  logic [SEL_W-1:0]    drink_idx_q;
  logic                change_q;
  logic [MONEY_W-1:0]  change_amt_q;
  logic                coin_rej_q;
  logic                sel_rej_q;
  sel_err_t            sel_err_q;
  logic                busy_q;
  logic [N_DRINKS-1:0] sold_vec;

  logic [MONEY_W:0]   coin_sum;
  logic               coin_seen, coin_take, coin_rej;
  logic               code_ok, sel_sold;
  logic [MONEY_W-1:0] sel_price;
  sel_err_t           sel_chk;
  logic               cancel_go, sel_go, sel_rej;
  sel_err_t           sel_rej_code;
  logic               open_state;

  always_comb begin
    open_state = (state == IDLE) || (state == CREDIT);
    coin_seen  = bus.coin_valid && (bus.coin_amt != '0);
    coin_sum   = {1'b0, credit_q} + {1'b0, bus.coin_amt};
    code_ok    = (bus.sel != '0) && (int'(bus.sel) <= N_DRINKS);

    sel_price = '0;
    sel_sold  = 1'b0;
    if (code_ok) sel_price = MONEY_W'(price_of(TBL, 32'(bus.sel), MONEY_W));
    for (int k = 0; k < N_DRINKS; k++) begin
      if (int'(bus.sel) == k + 1) sel_sold = sold_vec[k];
    end

    if (!code_ok)                  sel_chk = ERR_CODE;
    else if (sel_sold)             sel_chk = ERR_SOLD;
    else if (credit_q < sel_price) sel_chk = ERR_FUNDS;
    else                           sel_chk = ERR_NONE;

    // Cancel beats selection beats coin; a displaced coin is handed back.
    cancel_go    = bus.cancel && (state == CREDIT);
    sel_go       = !cancel_go && (state == CREDIT) && bus.sel_valid && (sel_chk == ERR_NONE);
    sel_rej      = bus.sel_valid && ((state == IDLE) ||
                   ((state == CREDIT) && !cancel_go && (sel_chk != ERR_NONE)));
    sel_rej_code = (state == IDLE) ? ERR_FUNDS : sel_chk;
    coin_take    = coin_seen && open_state && !cancel_go && !sel_go && (coin_sum <= MAX_C);
    coin_rej     = coin_seen && !coin_take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      credit_q     <= '0;
      drink_q      <= 1'b0;
      drink_idx_q  <= '0;
      change_q     <= 1'b0;
      change_amt_q <= '0;
      coin_rej_q   <= 1'b0;
      sel_rej_q    <= 1'b0;
      sel_err_q    <= ERR_NONE;
      busy_q       <= 1'b0;
    end else begin
      drink_q    <= 1'b0;
      change_q   <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= coin_rej;
      sel_rej_q  <= sel_rej;
      sel_err_q  <= sel_rej ? sel_rej_code : ERR_NONE;

      case (state)
        IDLE, CREDIT: begin
          if (cancel_go) begin
            state        <= CHANGE;
            busy_q       <= 1'b1;
            change_q     <= 1'b1;
            change_amt_q <= credit_q;
            credit_q     <= '0;
          end else if (sel_go) begin
            state       <= VEND;
            busy_q      <= 1'b1;
            drink_q     <= 1'b1;
            drink_idx_q <= bus.sel;
            credit_q    <= credit_q - sel_price;
          end else if (coin_take) begin
            state    <= CREDIT;
            credit_q <= coin_sum[MONEY_W-1:0];
          end
        end

        VEND: begin
          if ((MULTI_VEND != 0) && (credit_q >= MIN_PRICE)) begin
            state <= CREDIT;
          end else if (credit_q != '0) begin
            state        <= CHANGE;
            busy_q       <= 1'b1;
            change_q     <= 1'b1;
            change_amt_q <= credit_q;
            credit_q     <= '0;
          end else begin
            state <= IDLE;
          end
        end

        CHANGE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  vm_stock_bank #(
    .N_DRINKS  (N_DRINKS),
    .SEL_W     (SEL_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk          (clk),
    .rst          (rst),
    .vend_valid   (sel_go),
    .vend_idx     (bus.sel),
    .restock_valid(bus.restock_valid),
    .restock_idx  (bus.restock_idx),
    .restock_cnt  (bus.restock_cnt),
    .sold_out     (sold_vec)
  );

  assign bus.credit       = credit_q;
  assign bus.drink_valid  = drink_q;
  assign bus.drink_idx    = drink_idx_q;
  assign bus.change_valid = change_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.coin_reject  = coin_rej_q;
  assign bus.sel_reject   = sel_rej_q;
  assign bus.sel_err      = sel_err_q;
  assign bus.sold_out     = sold_vec;
  assign bus.busy         = busy_q;
endmodule
